rr_frame_arbiter: RTL
=====================

Name: rr_frame_arbiter

Overview:
- Next-generation crossbar output-port arbiter with NUM_PORTS requesters.
- Grants one ingress port, then locks that grant for a whole frame, so the crossbar never interleaves beats from different sources.
- Fairness is round-robin via a rotating priority pointer.
- A programmable hold watchdog releases a port that stalls mid-frame. The block sits per egress port in the xbar, between the ingress request lines and the egress mux select.

Parameters:
- NUM_PORTS, 4, number of requesting ingress ports; legal values ≥2, non-power-of-two allowed.
- IDX_W, clog2(NUM_PORTS), width of the grant index (derived, not overridden).
- MAX_HOLD, 1024, maximum cycles a grant may stay locked; 0 disables the watchdog.
- CNT_W, 16, hold-counter width; must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- iClk  input  1  clock.
- iRst_n  input  1  reset, asynchronous, active-low.
- iReq  input  NUM_PORTS  per-port request, level; held high while the port has a frame pending or in flight.
- iBeatValid  input  1  a data beat from the granted port transfers this cycle.
- iLast  input  1  the transferring beat is the last of the frame; qualified by iBeatValid.
- oGrant  output  IDX_W  index of the granted port (registered).
- oGrantOh  output  NUM_PORTS  one-hot form of oGrant; all zero when oGrantValid=0.
- oGrantValid  output  1  a grant is active (registered).
- oTimeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (async): oGrant=0, oGrantOh=0, oGrantValid=0, oTimeout=0, priority pointer ptr=0, hold counter=0, state=IDLE. Reset mid-lock aborts the lock with no release pulse.
- Selection (combinational):
  - Pick the first set iReq bit at index ptr, ptr+1, …, NUM_PORTS-1, 0, …, ptr-1.
  - Wrap is modulo NUM_PORTS; there are no phantom indices.
- State IDLE:
  - oGrantValid=0.
  - If any iReq is set, the next edge registers the selected index: oGrant=idx, oGrantOh=1<<idx, oGrantValid=1, counter=0, state→LOCK.
  - Latency is 1 cycle from iReq rising to oGrantValid.
- State LOCK:
  - The grant is held.
  - Counter increments each cycle and saturates at MAX_HOLD.
  - iReq changes on non-granted ports are ignored.
- Release condition (evaluated in LOCK), any of:
  - (a) iBeatValid & iLast;
  - (b) iReq[oGrant]=0;
  - (c) MAX_HOLD≠0 and counter==MAX_HOLD-1.
- On release:
  - ptr←(oGrant+1) mod NUM_PORTS.
  - Selection uses this updated pointer in the same cycle.
  - The released port therefore has lowest priority and is re-granted only if it is the sole requester.
- Back-to-back after release:
  - If any request exists in the release cycle, the next edge loads the new grant directly.
  - oGrantValid stays 1 with no idle bubble, and the counter clears.
  - Otherwise go to IDLE with oGrantValid=0 and oGrantOh=0.
- oTimeout:
  - Asserted for exactly the cycle after a release caused only by (c).
  - If (a) or (b) coincides with (c), oTimeout=0.
- iLast without iBeatValid is ignored. iBeatValid/iLast in IDLE are ignored.
- Simultaneous (a) and (b) produce one release only; ptr advances once.
- The request index is never out of range: oGrant < NUM_PORTS always.

Decomposition:
- Shared package xbar_pkg: clog2 function, default NUM_PORTS/MAX_HOLD constants, state encoding localparams (IDLE, LOCK).
- Sub-module rr_prio_pick (combinational):
  - Inputs: req vector and ptr.
  - Outputs: any and idx.
  - Implemented as a masked/unmasked two-pass priority encode.
  - Reused by other xbar arbiters.
- Top: rr_frame_arbiter contains the FSM, ptr, the hold counter and the output registers.

Test Plan (NUM_PORTS=4, MAX_HOLD=8 unless noted):
- Reset release, iReq=0000 for 5 cycles → oGrantValid=0, oGrantOh=0000, oTimeout=0 throughout.
- iReq=1111 held; each frame 3 beats, iLast on beat 3 → grants in order 0,1,2,3,0; oGrantValid never drops between frames.
- Port 2 granted; iReq[1] and iReq[3] rise mid-frame → oGrant stays 2 until iLast; next grant=3 on the following edge, then 1.
- Port 0 granted, sends beats without iLast for 8 cycles, iReq=0011 → oTimeout=1 for one cycle, oGrant becomes 1 with no bubble.
- Port 1 granted; iLast and the watchdog expiry occur in the same cycle → oTimeout stays 0; ptr advances once; next grant is 2 if requested.
- NUM_PORTS=3, MAX_HOLD=0, iReq=101, 100-cycle frames → no timeout; grants alternate 0,2,0.
- Mid-lock reset: assert iRst_n=0 → outputs clear asynchronously; first grant after reset starts from port 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: default sizing, arbiter state encoding and a
// constant-safe clog2 used to size grant indices.
package xbar_pkg;

   localparam int NUM_PORTS_DEF = 4;
   localparam int MAX_HOLD_DEF  = 1024;
   localparam int CNT_W_DEF     = 16;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // Index width is at least one bit so a two-port arbiter still has a grant bus.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority pick: first set request at ptr, ptr+1, ... wrapping to 0.
// Two-pass encode: requests at or above ptr win, otherwise lowest request overall.
module rr_prio_pick
   import xbar_pkg::*;
#(
   parameter  int NUM_PORTS = NUM_PORTS_DEF,
   localparam int IDX_W     = clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [IDX_W-1:0]     ptr_i,
   output logic                 any_o,
   output logic [IDX_W-1:0]     idx_o
);

   logic [NUM_PORTS-1:0] masked;
   logic                 hit_m;
   logic                 hit_u;
   logic [IDX_W-1:0]     idx_m;
   logic [IDX_W-1:0]     idx_u;

   always_comb begin
      masked = '0;
      hit_m  = 1'b0;
      hit_u  = 1'b0;
      idx_m  = '0;
      idx_u  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         masked[i] = req_i[i] && (i >= int'(ptr_i));
      end
      // Descending scan leaves the lowest set index in each pass.
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (masked[i]) begin
            hit_m = 1'b1;
            idx_m = IDX_W'(i);
         end
         if (req_i[i]) begin
            hit_u = 1'b1;
            idx_u = IDX_W'(i);
         end
      end
      any_o = hit_u;
      idx_o = hit_m ? idx_m : idx_u;
   end

endmodule

// File: rtl/rr_frame_arbiter.sv
// Per-egress frame arbiter: round-robin grant locked for a whole frame, with a
// hold watchdog that force-releases a port stalling mid-frame.
//
//   state | meaning
//   IDLE  | no grant; next requester is loaded on the following edge
//   LOCK  | grant held until last beat, request drop or watchdog expiry
module rr_frame_arbiter
   import xbar_pkg::*;
#(
   parameter  int NUM_PORTS = NUM_PORTS_DEF,
   parameter  int MAX_HOLD  = MAX_HOLD_DEF,
   parameter  int CNT_W     = CNT_W_DEF,
   localparam int IDX_W     = clog2(NUM_PORTS)
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic [NUM_PORTS-1:0] iReq,
   input  logic                 iBeatValid,
   input  logic                 iLast,
   output logic [IDX_W-1:0]     oGrant,
   output logic [NUM_PORTS-1:0] oGrantOh,
   output logic                 oGrantValid,
   output logic                 oTimeout
);

   localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PORTS - 1);

   arb_state_e           state_q, state_d;
   logic [IDX_W-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [NUM_PORTS-1:0] oh_q, oh_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 timeout_q, timeout_d;

   logic                 rel_last, rel_drop, rel_wdog, release_now;
   logic [IDX_W-1:0]     ptr_after, pick_ptr, pick_idx;
   logic                 pick_any;

   assign rel_last    = iBeatValid & iLast;
   assign rel_drop    = ~iReq[grant_q];
   assign rel_wdog    = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
   assign release_now = (state_q == LOCK) && (rel_last || rel_drop || rel_wdog);
   assign ptr_after   = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
   // A releasing port drops to lowest priority for the very same pick.
   assign pick_ptr    = release_now ? ptr_after : ptr_q;

   rr_prio_pick #(
      .NUM_PORTS (NUM_PORTS)
   ) u_pick (
      .req_i (iReq),
      .ptr_i (pick_ptr),
      .any_o (pick_any),
      .idx_o (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      oh_d      = oh_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = LOCK;
               grant_d = pick_idx;
               oh_d    = NUM_PORTS'(1) << pick_idx;
               cnt_d   = '0;
            end
         end
         LOCK: begin
            if (release_now) begin
               ptr_d     = ptr_after;
               timeout_d = rel_wdog && !rel_last && !rel_drop;
               if (pick_any) begin
                  grant_d = pick_idx;
                  oh_d    = NUM_PORTS'(1) << pick_idx;
                  cnt_d   = '0;
               end else begin
                  state_d = IDLE;
                  oh_d    = '0;
               end
            end else if (cnt_q != HOLD_SAT) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         oh_q      <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         oh_q      <= oh_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign oGrant      = grant_q;
   assign oGrantOh    = oh_q;
   assign oGrantValid = (state_q == LOCK);
   assign oTimeout    = timeout_q;

endmodule
